dist_sqrt_client: RTL

//  Initiator side of the iterative square-root unit. Accepts a signed fixed-point delta vector (dx,dy,dz)
//  and forms dx^2+dy^2+dz^2 over three cycles with one shared squarer.

---
 rtl/dist_sqrt_client_pkg.sv | 25 ++
 rtl/dist_sqrt_client_sum_sq_accum.sv | 60 ++++++
 rtl/dist_sqrt_client.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dist_sqrt_client_pkg.sv
// Shared types and constants for the distance / square-root client.
// No logic: the state enum, root-unit A/Q widths and the radicand clamp value.
// Q width defaults to 6 bits (4 integer, 2 fractional: the root of a 4-fraction-bit radicand).
`ifndef DIS_SQRT_B
`define DIS_SQRT_B 6
`endif

package dist_sqrt_client_pkg;
   localparam int D_B_DEF    = 10;
   localparam int D_FP_B_DEF = 4;
   localparam int A_INT_B    = 8;
   localparam int A_FP_B     = 4;
   localparam int A_B        = A_INT_B + A_FP_B;
   localparam int Q_B        = `DIS_SQRT_B;
   localparam logic [A_B-1:0] SAT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQUARE,
      S_PACK,
      S_REQ,
      S_WAIT,
      S_OUT
   } sqrt_client_state_t;
endpackage

// File: rtl/dist_sqrt_client_sum_sq_accum.sv
// Sum of squares of three signed deltas through one shared squarer.
// Latency: start cycle latches, then three accumulate cycles; done is high in the last one.
// No backpressure: once started it runs to completion; start restarts it.
module sum_sq_accum #(
   parameter int D_B = 10
) (
   input  logic           clk,
   input  logic           rst_,
   input  logic           start,
   input  logic [D_B-1:0] dx,
   input  logic [D_B-1:0] dy,
   input  logic [D_B-1:0] dz,
   output logic           done,
   output logic [2*D_B:0] acc
);
   logic [D_B-1:0]   lx, ly, lz;
   logic [D_B-1:0]   sel;
   logic [D_B-1:0]   mag;
   logic [2*D_B-1:0] prod;
   logic [1:0]       idx;
   logic             run;

   // Pick the delta for this step.
   always_comb begin
      sel = lx;
      case (idx)
         2'd1:    sel = ly;
         2'd2:    sel = lz;
         default: sel = lx;
      endcase
   end

   // Magnitude as unsigned D_B bits: the most negative value maps to 2^(D_B-1) exactly.
   assign mag  = sel[D_B-1] ? (-sel) : sel;
   assign prod = mag * mag;
   assign done = run && (idx == 2'd2);

   // Latch deltas on start, then accumulate one square per cycle.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         lx  <= '0;
         ly  <= '0;
         lz  <= '0;
         acc <= '0;
         idx <= '0;
         run <= 1'b0;
      end else if (start) begin
         lx  <= dx;
         ly  <= dy;
         lz  <= dz;
         acc <= '0;
         idx <= '0;
         run <= 1'b1;
      end else if (run) begin
         acc <= acc + {1'b0, prod};
         idx <= idx + 2'd1;
         if (idx == 2'd2) run <= 1'b0;
      end
   end
endmodule

// File: rtl/dist_sqrt_client.sv
// Distance client: sums squared deltas, feeds the root unit, returns the root.
// Latency: accept 0, squares 1-3, pack 4, start from 5; result one cycle after busy falls.
// Backpressure: one vector in flight; in_ready only in IDLE; OUT holds until out_ready.
module dist_sqrt_client
   import dist_sqrt_client_pkg::*;
#(
   parameter int D_B     = D_B_DEF,
   parameter int D_FP_B  = D_FP_B_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst_,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [D_B-1:0] dx,
   input  logic [D_B-1:0] dy,
   input  logic [D_B-1:0] dz,
   output logic           sqrt_start,
   output logic [A_B-1:0] sqrt_a,
   input  logic           sqrt_busy,
   input  logic [Q_B-1:0] sqrt_q,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [Q_B-1:0] out_dist,
   output logic           out_err
);
   localparam int ACC_B = 2*D_B + 1;
   localparam int SH    = 2*D_FP_B - A_FP_B;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   sqrt_client_state_t st, nxt;
   logic [ACC_B-1:0]   acc;
   logic [ACC_B-1:0]   acc_sh;
   logic [A_B-1:0]     sat_a;
   logic               acc_done;
   logic [TW-1:0]      to_cnt;
   logic               to_hit;

   sum_sq_accum #(.D_B(D_B)) u_acc (
      .clk   (clk),
      .rst_  (rst_),
      .start (in_valid && in_ready),
      .dx    (dx),
      .dy    (dy),
      .dz    (dz),
      .done  (acc_done),
      .acc   (acc)
   );

   // A sum whose radicand truncates to zero is answered directly: the root unit stalls on A=0.
   assign acc_sh = acc >> SH;
   assign sat_a  = (acc_sh > ACC_B'(SAT_MAX)) ? SAT_MAX : acc_sh[A_B-1:0];
   assign to_hit = (to_cnt == TO_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) st <= S_IDLE;
      else       st <= nxt;
   end

   // Next state and state-decoded handshake outputs.
   always_comb begin
      nxt        = st;
      in_ready   = 1'b0;
      sqrt_start = 1'b0;
      out_valid  = 1'b0;
      case (st)
         S_IDLE: begin
            in_ready = rst_;
            if (in_valid && rst_) nxt = S_SQUARE;
         end
         S_SQUARE: if (acc_done) nxt = S_PACK;
         S_PACK:   nxt = (sat_a == '0) ? S_OUT : S_REQ;
         S_REQ: begin
            sqrt_start = 1'b1;
            if (to_hit)         nxt = S_OUT;
            else if (sqrt_busy) nxt = S_WAIT;
         end
         S_WAIT: if (!sqrt_busy || to_hit) nxt = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Radicand, result capture and timeout counter; a capture beats a same-cycle timeout.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sqrt_a   <= '0;
         out_dist <= '0;
         out_err  <= 1'b0;
         to_cnt   <= '0;
      end else begin
         case (st)
            S_PACK: begin
               to_cnt <= '0;
               if (sat_a == '0) begin
                  out_dist <= '0;
                  out_err  <= 1'b0;
               end else begin
                  sqrt_a <= sat_a;
               end
            end
            S_REQ, S_WAIT: begin
               to_cnt <= to_cnt + 1'b1;
               if (st == S_WAIT && !sqrt_busy) begin
                  out_dist <= sqrt_q;
                  out_err  <= 1'b0;
               end else if (to_hit) begin
                  out_dist <= '0;
                  out_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
